bbox_sample_walker: RTL and testbench
=====================================

// Module: bbox_sample_walker
// PURPOSE
//  Rasterizer stage that walks a triangle's bounding box one sample per cycle.
//  Sits upstream of the jitter/hash stage, which in turn feeds the sample-test stage.
//  Accepts one triangle plus its box per handshake and emits every sample
//  location in the box (row-major: x fastest, then y).
//  Halts the bounding-box stage while a walk is in progress.
// PARAMETERS
//  SIGFIG   24  bits in color and position (signed fixed point)
//  RADIX    10  fraction bits
//  VERTS     3  vertices per triangle
//  AXIS      3  axes per vertex (x,y,z)
//  COLORS    3  color channels
// PORTS
//  clk            in   1                   clock; single clock domain
//  rst            in   1                   asynchronous, active-low reset
//  tri_R13S       in   SIGFIG x VERTS x AXIS   triangle
//  color_R13U     in   SIGFIG x COLORS     triangle color
//  box_R13S       in   SIGFIG x 2 x 2      [0]=lower-left, [1]=upper-right; [][0]=x, [][1]=y
//  validTri_R13H  in   1                   triangle/box present
//  subSample_RnnnnU in 4                   one-hot: 1000=1x, 0100=2x, 0010=4x, 0001=8x
//  halt_RnnnnH    out  1                   upstream must hold its inputs
//  tri_R14S       out  SIGFIG x VERTS x AXIS   latched triangle
//  color_R14U     out  SIGFIG x COLORS     latched color
//  sample_R14S    out  SIGFIG x 2          current sample (x,y)
//  validSamp_R14H out  1                   sample_R14S is valid this cycle
// BEHAVIOUR
//  - Reset (rst=0, async): state=WAIT; all outputs 0, including halt_RnnnnH and validSamp_R14H.
//  - Step is decoded from subSample_RnnnnU at accept time:
//      1x = 1<<RADIX, 2x = 1<<(RADIX-1), 4x = 1<<(RADIX-2), 8x = 1<<(RADIX-3).
//    The step is latched. A subsample change mid-walk has no effect until the next accept.
//    A non-one-hot code is treated as 1x.
//  - Accept: validTri_R13H && !halt_RnnnnH. At the next edge the block:
//      latches tri, color, box and step;
//      sets sample_R14S = box lower-left;
//      sets validSamp_R14H = 1;
//      sets state = TEST.
//    Latency from accept to first sample is 1 cycle.
//  - Invalid box (ll.x>ur.x or ll.y>ur.y): the triangle is consumed; no samples; state stays WAIT.
//  - TEST state, each edge:
//      if x+step <= ur.x: x += step;
//      else if y+step <= ur.y: x = ll.x, y += step;
//      else: last sample was just emitted.
//    Comparisons use SIGFIG+1-bit signed sums, so there is no wrap-around.
//  - last_R14H = (x+step > ur.x) && (y+step > ur.y).
//  - halt_RnnnnH = (state==TEST) && !last_R14H. It is combinational from registered state.
//  - On the last-sample cycle halt is low, so a new triangle can be accepted in the same cycle.
//    Back-to-back triangles therefore have zero bubbles.
//  - If no new triangle is accepted on the last-sample cycle:
//      next edge sets state=WAIT and validSamp_R14H=0.
//  - Degenerate box (ll==ur) yields exactly one sample; halt never rises.
//  - tri_R14S and color_R14U hold constant for the whole walk.
//    They change only on accept.
//  - Throughput: 1 sample/cycle. Samples per triangle = ((ur.x-ll.x)/step+1)*((ur.y-ll.y)/step+1).
//  - Box corners are step-aligned; this is guaranteed by the bounding-box stage.
// STRUCTURE
//  - rast_pkg: walker_state_t enum {WAIT, TEST}; one-hot subsample codes SS_1X/2X/4X/8X.
//  - No sub-module. The step decoder, next-sample adders and FSM are all in this file.
//  - All R14 outputs come from plain flops. This block adds no retiming registers.
// TESTING  (RADIX=10)
//  1. Basic walk: 1x, box ll=(0,0) ur=(1024,1024).
//     -> samples (0,0),(1024,0),(0,1024),(1024,1024) on 4 consecutive cycles.
//     -> halt high for 3 cycles, low on the 4th.
//  2. 4x walk: box ll=(512,256) ur=(768,256).
//     -> samples (512,256),(768,256); validSamp then drops.
//  3. Back-to-back: second triangle asserted on the last-sample cycle of test 1.
//     -> its first sample appears on the very next cycle with no gap.
//     -> tri_R14S switches in that same cycle.
//  4. Boundary boxes: ll==ur=(2048,2048) -> one sample, halt stays 0.
//     ll.x=1024 > ur.x=0 -> zero samples, validSamp stays 0.
//  5. Reset mid-walk: rst low after sample 2 of test 1.
//     -> outputs 0 immediately (asynchronous).
//     -> after release, state is WAIT and the next triangle walks from its own ll.
//  6. Subsample toggled 1x->8x mid-walk -> current walk keeps step 1024.

Source files
------------

// File: rtl/rast_pkg.sv
// Shared types, constants and helpers for the rasterizer sample walker.
// Positions are signed fixed point with RADIX fraction bits.
package rast_pkg;

  localparam int SIGFIG = 24;
  localparam int RADIX  = 10;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;

  // Walker FSM: idle and waiting for a triangle, or stepping through a box
  typedef enum logic [0:0] {
    WAIT = 1'b0,
    TEST = 1'b1
  } walker_state_t;

  // One-hot subsample codes
  localparam logic [3:0] SS_1X = 4'b1000;
  localparam logic [3:0] SS_2X = 4'b0100;
  localparam logic [3:0] SS_4X = 4'b0010;
  localparam logic [3:0] SS_8X = 4'b0001;

  typedef logic [SIGFIG-1:0]        fix_t;
  typedef logic signed [SIGFIG:0]   wide_t;

  // Sample pitch for a subsample code; anything not one-hot walks at 1x
  function automatic fix_t decode_step(input logic [3:0] ss);
    fix_t step;
    case (ss)
      SS_1X:   step = fix_t'(1) << RADIX;
      SS_2X:   step = fix_t'(1) << (RADIX - 1);
      SS_4X:   step = fix_t'(1) << (RADIX - 2);
      SS_8X:   step = fix_t'(1) << (RADIX - 3);
      default: step = fix_t'(1) << RADIX;
    endcase
    return step;
  endfunction

  // Sign-extend a coordinate by one bit so sums and compares cannot wrap
  function automatic wide_t widen(input fix_t a);
    return wide_t'({a[SIGFIG-1], a});
  endfunction

endpackage

// File: rtl/bbox_sample_walker.sv
// Bounding-box sample walker: accepts one triangle and its box per handshake
// and emits every sample location in the box, x fastest then y, one per cycle.
// The upstream bounding-box stage is halted for the duration of a walk, except
// on the last-sample cycle so a following triangle enters with no bubble.
module bbox_sample_walker
  import rast_pkg::*;
(
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S,
  input  logic [COLORS-1:0][SIGFIG-1:0]         color_R13U,
  input  logic [1:0][1:0][SIGFIG-1:0]           box_R13S,
  input  logic                                  validTri_R13H,
  input  logic [3:0]                            subSample_RnnnnU,
  output logic                                  halt_RnnnnH,
  output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
  output logic [COLORS-1:0][SIGFIG-1:0]         color_R14U,
  output logic [1:0][SIGFIG-1:0]                sample_R14S,
  output logic                                  validSamp_R14H
);

  // Box indices: [0]=lower-left, [1]=upper-right; coordinate [0]=x, [1]=y
  localparam int LL = 0;
  localparam int UR = 1;
  localparam int X  = 0;
  localparam int Y  = 1;

  walker_state_t state_q, state_d;
  fix_t          step_q, step_d;
  logic [1:0][1:0][SIGFIG-1:0]           box_q, box_d;
  logic [1:0][SIGFIG-1:0]                sample_q, sample_d;
  logic                                  valid_q, valid_d;
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q, tri_d;
  logic [COLORS-1:0][SIGFIG-1:0]         color_q, color_d;

  wide_t x_sum_s;
  wide_t y_sum_s;
  logic  x_fits_s;
  logic  y_fits_s;
  logic  last_R14H;
  logic  accept_s;
  logic  box_bad_s;

  // Next-sample adders and end-of-walk detection from the registered walk state
  always_comb begin
    x_sum_s   = widen(sample_q[X]) + widen(step_q);
    y_sum_s   = widen(sample_q[Y]) + widen(step_q);
    x_fits_s  = (x_sum_s <= widen(box_q[UR][X]));
    y_fits_s  = (y_sum_s <= widen(box_q[UR][Y]));
    last_R14H = !x_fits_s && !y_fits_s;
  end

  // Upstream hold; on the last sample the port opens for the next triangle
  always_comb begin
    halt_RnnnnH = (state_q == TEST) && !last_R14H;
  end

  // Handshake and incoming-box sanity check
  always_comb begin
    accept_s  = validTri_R13H && !halt_RnnnnH;
    box_bad_s = ($signed(box_R13S[LL][X]) > $signed(box_R13S[UR][X])) ||
                ($signed(box_R13S[LL][Y]) > $signed(box_R13S[UR][Y]));
  end

  // Walker FSM next-state and datapath updates
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    box_d    = box_q;
    sample_d = sample_q;
    valid_d  = valid_q;
    tri_d    = tri_q;
    color_d  = color_q;

    if (accept_s) begin
      // Triangle is consumed even if its box is empty
      step_d  = decode_step(subSample_RnnnnU);
      box_d   = box_R13S;
      tri_d   = tri_R13S;
      color_d = color_R13U;
      if (box_bad_s) begin
        state_d = WAIT;
        valid_d = 1'b0;
      end else begin
        state_d  = TEST;
        valid_d  = 1'b1;
        sample_d = box_R13S[LL];
      end
    end else begin
      case (state_q)
        TEST: begin
          if (x_fits_s) begin
            sample_d[X] = x_sum_s[SIGFIG-1:0];
          end else if (y_fits_s) begin
            sample_d[X] = box_q[LL][X];
            sample_d[Y] = y_sum_s[SIGFIG-1:0];
          end else begin
            // Last sample already emitted and nothing new arrived
            state_d = WAIT;
            valid_d = 1'b0;
          end
        end
        WAIT: begin
          valid_d = 1'b0;
        end
        default: begin
          state_d = WAIT;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= WAIT;
      step_q   <= '0;
      box_q    <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      tri_q    <= '0;
      color_q  <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      box_q    <= box_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      tri_q    <= tri_d;
      color_q  <= color_d;
    end
  end

  // Stage outputs come straight from the flops
  always_comb begin
    tri_R14S       = tri_q;
    color_R14U     = color_q;
    sample_R14S    = sample_q;
    validSamp_R14H = valid_q;
  end

endmodule

// File: tb/tb_bbox_sample_walker.sv
// Directed bench for bbox_sample_walker (RADIX=10, so 1x step = 1024).
module tb_bbox_sample_walker;
  import rast_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_in, tri_out;
  logic [COLORS-1:0][SIGFIG-1:0]         color_in, color_out;
  logic [1:0][1:0][SIGFIG-1:0]           box_in;
  logic                                  valid_in;
  logic [3:0]                            ss_in;
  logic                                  halt;
  logic [1:0][SIGFIG-1:0]                samp_out;
  logic                                  valid_out;

  int errors = 0;
  int checks = 0;

  bbox_sample_walker dut (
    .clk              (clk),
    .rst              (rst),
    .tri_R13S         (tri_in),
    .color_R13U       (color_in),
    .box_R13S         (box_in),
    .validTri_R13H    (valid_in),
    .subSample_RnnnnU (ss_in),
    .halt_RnnnnH      (halt),
    .tri_R14S         (tri_out),
    .color_R14U       (color_out),
    .sample_R14S      (samp_out),
    .validSamp_R14H   (valid_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] xy(input int x, input int y);
    logic [23:0] xs;
    logic [23:0] ys;
    xs = x[23:0];
    ys = y[23:0];
    return 256'({xs, ys});
  endfunction

  function automatic logic [255:0] samp();
    return 256'({samp_out[0], samp_out[1]});
  endfunction

  function automatic logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_pat(input int seed);
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] t;
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++)
        t[v][a] = 24'(seed * 4096 + v * 3 + a + 1);
    return t;
  endfunction

  function automatic logic [COLORS-1:0][SIGFIG-1:0] color_pat(input int seed);
    logic [COLORS-1:0][SIGFIG-1:0] c;
    for (int i = 0; i < COLORS; i++)
      c[i] = 24'(seed * 8192 + 256 + i);
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int llx, input int lly, input int urx, input int ury,
                      input logic [3:0] ss, input int seed);
    box_in[0][0] = llx[23:0];
    box_in[0][1] = lly[23:0];
    box_in[1][0] = urx[23:0];
    box_in[1][1] = ury[23:0];
    ss_in    = ss;
    tri_in   = tri_pat(seed);
    color_in = color_pat(seed);
    valid_in = 1'b1;
  endtask

  initial begin
    rst      = 1'b0;
    tri_in   = '0;
    color_in = '0;
    box_in   = '0;
    valid_in = 1'b0;
    ss_in    = SS_1X;
    #2;
    chk("rst_valid", 256'(valid_out), 256'(1'b0));
    chk("rst_halt",  256'(halt),      256'(1'b0));
    chk("rst_samp",  samp(),          xy(0, 0));
    chk("rst_tri",   256'(tri_out),   256'(0));
    chk("rst_color", 256'(color_out), 256'(0));
    #20 rst = 1'b1;
    tick();

    // Basic 1x walk over a 2x2 box
    load(0, 0, 1024, 1024, SS_1X, 1);
    chk("t1_idle_halt", 256'(halt), 256'(1'b0));
    tick();
    valid_in = 1'b0;
    chk("t1_s0_valid", 256'(valid_out), 256'(1'b1));
    chk("t1_s0",       samp(),          xy(0, 0));
    chk("t1_s0_halt",  256'(halt),      256'(1'b1));
    chk("t1_tri",      256'(tri_out),   256'(tri_pat(1)));
    chk("t1_color",    256'(color_out), 256'(color_pat(1)));
    tick();
    chk("t1_s1",      samp(),     xy(1024, 0));
    chk("t1_s1_halt", 256'(halt), 256'(1'b1));
    tick();
    chk("t1_s2",      samp(),     xy(0, 1024));
    chk("t1_s2_halt", 256'(halt), 256'(1'b1));
    tick();
    chk("t1_s3",       samp(),          xy(1024, 1024));
    chk("t1_s3_halt",  256'(halt),      256'(1'b0));
    chk("t1_s3_valid", 256'(valid_out), 256'(1'b1));
    chk("t1_s3_tri",   256'(tri_out),   256'(tri_pat(1)));

    // Back-to-back: 4x triangle offered on the last-sample cycle
    load(512, 256, 768, 256, SS_4X, 2);
    tick();
    valid_in = 1'b0;
    chk("t3_s0_valid", 256'(valid_out), 256'(1'b1));
    chk("t3_s0",       samp(),          xy(512, 256));
    chk("t3_tri",      256'(tri_out),   256'(tri_pat(2)));
    chk("t3_color",    256'(color_out), 256'(color_pat(2)));
    chk("t2_s0_halt",  256'(halt),      256'(1'b1));
    tick();
    chk("t2_s1",       samp(),          xy(768, 256));
    chk("t2_s1_halt",  256'(halt),      256'(1'b0));
    chk("t2_s1_tri",   256'(tri_out),   256'(tri_pat(2)));
    tick();
    chk("t2_end_valid", 256'(valid_out), 256'(1'b0));
    chk("t2_end_halt",  256'(halt),      256'(1'b0));

    // Degenerate box: single sample, no halt
    load(2048, 2048, 2048, 2048, SS_1X, 3);
    tick();
    valid_in = 1'b0;
    chk("t4a_s0",       samp(),          xy(2048, 2048));
    chk("t4a_s0_valid", 256'(valid_out), 256'(1'b1));
    chk("t4a_s0_halt",  256'(halt),      256'(1'b0));
    tick();
    chk("t4a_end_valid", 256'(valid_out), 256'(1'b0));
    chk("t4a_end_halt",  256'(halt),      256'(1'b0));

    // Inverted box: consumed, no samples
    load(1024, 0, 0, 0, SS_1X, 4);
    tick();
    valid_in = 1'b0;
    chk("t4b_valid0", 256'(valid_out), 256'(1'b0));
    chk("t4b_halt0",  256'(halt),      256'(1'b0));
    tick();
    chk("t4b_valid1", 256'(valid_out), 256'(1'b0));

    // Asynchronous reset in the middle of a walk
    load(0, 0, 1024, 1024, SS_1X, 5);
    tick();
    valid_in = 1'b0;
    tick();
    chk("t5_s1",      samp(),     xy(1024, 0));
    chk("t5_s1_halt", 256'(halt), 256'(1'b1));
    #2 rst = 1'b0;
    #1;
    chk("t5_rst_valid", 256'(valid_out), 256'(1'b0));
    chk("t5_rst_halt",  256'(halt),      256'(1'b0));
    chk("t5_rst_samp",  samp(),          xy(0, 0));
    chk("t5_rst_tri",   256'(tri_out),   256'(0));
    #2 rst = 1'b1;
    tick();
    chk("t5_idle_valid", 256'(valid_out), 256'(1'b0));
    chk("t5_idle_halt",  256'(halt),      256'(1'b0));
    load(-1024, 2048, 0, 2048, SS_1X, 6);
    tick();
    valid_in = 1'b0;
    chk("t5b_s0",      samp(),     xy(-1024, 2048));
    chk("t5b_s0_halt", 256'(halt), 256'(1'b1));
    tick();
    chk("t5b_s1",      samp(),     xy(0, 2048));
    chk("t5b_s1_halt", 256'(halt), 256'(1'b0));
    tick();
    chk("t5b_end_valid", 256'(valid_out), 256'(1'b0));

    // Subsample changed mid-walk keeps the latched 1x step
    load(0, 0, 1024, 1024, SS_1X, 7);
    tick();
    valid_in = 1'b0;
    ss_in    = SS_8X;
    chk("t6_s0", samp(), xy(0, 0));
    tick();
    chk("t6_s1", samp(), xy(1024, 0));
    tick();
    chk("t6_s2", samp(), xy(0, 1024));
    tick();
    chk("t6_s3",      samp(),     xy(1024, 1024));
    chk("t6_s3_halt", 256'(halt), 256'(1'b0));
    tick();
    chk("t6_end_valid", 256'(valid_out), 256'(1'b0));

    // Non-one-hot code walks at 1x
    load(0, 0, 1024, 0, 4'b0110, 8);
    tick();
    valid_in = 1'b0;
    chk("nh_s0_halt", 256'(halt), 256'(1'b1));
    tick();
    chk("nh_s1",      samp(),     xy(1024, 0));
    chk("nh_s1_halt", 256'(halt), 256'(1'b0));
    tick();
    chk("nh_end_valid", 256'(valid_out), 256'(1'b0));

    // 8x step along x
    load(0, 0, 128, 0, SS_8X, 9);
    tick();
    valid_in = 1'b0;
    chk("x8_s0_halt", 256'(halt), 256'(1'b1));
    tick();
    chk("x8_s1",      samp(),     xy(128, 0));
    chk("x8_s1_halt", 256'(halt), 256'(1'b0));
    tick();

    // 2x step along y
    load(0, 0, 0, 512, SS_2X, 10);
    tick();
    valid_in = 1'b0;
    chk("x2_s0",      samp(),     xy(0, 0));
    chk("x2_s0_halt", 256'(halt), 256'(1'b1));
    tick();
    chk("x2_s1",      samp(),     xy(0, 512));
    chk("x2_s1_halt", 256'(halt), 256'(1'b0));
    tick();
    chk("x2_end_valid", 256'(valid_out), 256'(1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
